// File: rtl/jtframe_prog_pkg.sv
// Shared types for the ROM-download write path: the queued SDRAM write entry
// and the output FSM state encoding.
package jtframe_prog_pkg;

  typedef struct packed {
    logic [22:1] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } prog_entry_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WR   = 1'b1;

  localparam prog_entry_t PROG_RST = '{addr: 22'd0, data: 16'd0, mask: 2'b11};

  // Mask is active-low: a single-byte write has exactly one bit set.
  function automatic logic is_byte_mask(input logic [1:0] mask);
    return (mask == 2'b10) || (mask == 2'b01);
  endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Synchronous FIFO of prog_entry_t; the head is read combinationally so the
// output stage can load it in the same cycle it pops.
module jtframe_prog_fifo
  import jtframe_prog_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  prog_entry_t            push_data,
  input  logic                   pop,
  output prog_entry_t            head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

  prog_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en, rd_en;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_en && !rd_en) count_d = count_q + CW'(1);
    if (rd_en && !wr_en) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/jtframe_prog_merge.sv
// ROM-download write merger: pairs byte writes into half-words (when built with
// JTFRAME_PROG_MERGE_EN), queues them and issues them one by one to the SDRAM.
module jtframe_prog_merge
  import jtframe_prog_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IDLE_TO = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [22:1] in_addr,
  input  logic [15:0] in_data,
  input  logic [1:0]  in_mask,
  input  logic        in_we,
  output logic        in_ack,
  output logic [22:1] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  input  logic        sdram_ack,
  output logic        done
);

  localparam int CW = $clog2(DEPTH) + 1;

  prog_entry_t   in_entry, push_entry, head;
  logic          push, pop, full, empty, accept, hold_busy;
  logic [CW-1:0] count;
  logic          in_ack_q;

  assign in_entry = '{addr: in_addr, data: in_data, mask: in_mask};

  jtframe_prog_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

`ifdef JTFRAME_PROG_MERGE_EN
  localparam int IW = $clog2(IDLE_TO + 1);

  prog_entry_t   hold_q, hold_d;
  logic          hold_vld_q, hold_vld_d, flush_pend_q, flush_pend_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          in_byte, pair, room2, flush_due;

  assign in_byte   = is_byte_mask(in_mask);
  assign pair      = hold_vld_q && in_byte && (in_addr == hold_q.addr) && (in_mask == ~hold_q.mask);
  assign room2     = (count <= CW'(DEPTH - 2));
  assign flush_due = hold_vld_q && (flush_pend_q || (idle_q >= IW'(IDLE_TO)) || !downloading);
  // Any non-merging write while holding pushes the held entry, so it needs two slots.
  assign accept    = in_we && !in_ack_q && !full && !flush_due && (pair || !hold_vld_q || room2);
  assign hold_busy = hold_vld_q;

  always_comb begin
    hold_d       = hold_q;
    hold_vld_d   = hold_vld_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    push_entry   = in_entry;
    idle_d       = idle_q;
    if (!hold_vld_q)                    idle_d = '0;
    else if (idle_q < IW'(IDLE_TO))     idle_d = idle_q + IW'(1);
    if (accept) begin
      idle_d = '0;
      if (!hold_vld_q) begin
        if (in_byte) begin
          hold_d     = in_entry;
          hold_vld_d = 1'b1;
        end else begin
          push = 1'b1;
        end
      end else if (pair) begin
        push            = 1'b1;
        push_entry.mask = 2'b00;
        push_entry.data = (hold_q.mask == 2'b10) ? {in_data[15:8], hold_q.data[7:0]}
                                                 : {hold_q.data[15:8], in_data[7:0]};
        hold_vld_d      = 1'b0;
      end else begin
        // A full-word write parks behind the held entry and leaves next cycle.
        push         = 1'b1;
        push_entry   = hold_q;
        hold_d       = in_entry;
        hold_vld_d   = 1'b1;
        flush_pend_d = !in_byte;
      end
    end else if (flush_due && !full) begin
      push         = 1'b1;
      push_entry   = hold_q;
      hold_vld_d   = 1'b0;
      flush_pend_d = 1'b0;
      idle_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= PROG_RST;
      hold_vld_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      idle_q       <= '0;
    end else begin
      hold_q       <= hold_d;
      hold_vld_q   <= hold_vld_d;
      flush_pend_q <= flush_pend_d;
      idle_q       <= idle_d;
    end
  end
`else
  localparam int unused_idle_to = IDLE_TO;
  logic unused_count;

  assign unused_count = ^count;
  assign accept       = in_we && !in_ack_q && !full;
  assign push         = accept;
  assign push_entry   = in_entry;
  assign hold_busy    = 1'b0;
`endif

  logic [0:0]  state_q, state_d;
  prog_entry_t prog_q, prog_d;
  logic        prog_we_q, prog_we_d;

  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    prog_we_d = prog_we_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: if (!empty) begin
        prog_d    = head;
        prog_we_d = 1'b1;
        pop       = 1'b1;
        state_d   = ST_WR;
      end
      ST_WR: if (sdram_ack) begin
        prog_we_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      prog_q    <= PROG_RST;
      prog_we_q <= 1'b0;
      in_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      prog_we_q <= prog_we_d;
      in_ack_q  <= accept;
    end
  end

  assign in_ack    = in_ack_q;
  assign prog_addr = prog_q.addr;
  assign prog_data = prog_q.data;
  assign prog_mask = prog_q.mask;
  assign prog_we   = prog_we_q;
  assign done      = !downloading && !hold_busy && empty && !prog_we_q;

endmodule

// File: tb/tb_jtframe_prog_merge.sv
// Directed bench for jtframe_prog_merge; expectations follow JTFRAME_PROG_MERGE_EN.
module tb_jtframe_prog_merge;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [22:1] in_addr = '0;
  logic [15:0] in_data = '0;
  logic [1:0]  in_mask = 2'b11;
  logic        in_we = 1'b0;
  logic        in_ack;
  logic [22:1] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        sdram_ack = 1'b0;
  logic        done;

  logic        ack_en = 1'b0;
  logic [39:0] got_q[$];
  int          passed = 0;
  int          total = 0;

  always #5 clk = ~clk;

  jtframe_prog_merge #(.DEPTH(DEPTH), .IDLE_TO(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_mask     (in_mask),
    .in_we       (in_we),
    .in_ack      (in_ack),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_we     (prog_we),
    .sdram_ack   (sdram_ack),
    .done        (done)
  );

  // SDRAM model: one-cycle ack for each write request while enabled.
  initial forever begin
    @(negedge clk);
    sdram_ack = ack_en && prog_we && !sdram_ack;
  end

  always @(posedge clk) begin
    if (prog_we && sdram_ack) got_q.push_back({prog_addr, prog_data, prog_mask});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic send(input logic [22:1] a, input logic [15:0] d, input logic [1:0] m,
                      input int budget, output bit ok);
    in_addr = a; in_data = d; in_mask = m; in_we = 1'b1; ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ack) ok = 1'b1;
    end
    in_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_got(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && got_q.size() < n; i++) @(negedge clk);
    check(tag, got_q.size(), n);
  endtask

  initial begin
    bit ok;
    int accepted;
    int cyc;
    logic [39:0] exp_w [$];
    logic [7:0]  b;

    // Reset state
    idle(2);
    check("rst_in_ack", in_ack, 0);
    check("rst_prog_we", prog_we, 0);
    check("rst_prog_addr", prog_addr, 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_prog_mask", prog_mask, 2'b11);
    check("rst_done", done, 1);
    rst_n = 1'b1;
    idle(2);

    // Byte pair at the same address
    downloading = 1'b1;
    ack_en = 1'b1;
    got_q.delete();
    send(22'h10, 16'h3434, 2'b10, 20, ok);
    check("pair_ack_a", ok, 1);
    check("busy_done", done, 0);
`ifdef JTFRAME_PROG_MERGE_EN
    idle(1);
    check("held_no_we", prog_we, 0);
    check("ack_pulse", in_ack, 0);
    send(22'h10, 16'h1212, 2'b01, 20, ok);
    check("pair_ack_b", ok, 1);
    check("lat_pre", prog_we, 0);
    idle(1);
    check("lat_rise", prog_we, 1);
    wait_got("pair_count", 1, 40);
    check("pair_word", got_q[0], {22'h10, 16'h1234, 2'b00});
    idle(30);
    check("pair_no_extra", got_q.size(), 1);
`else
    check("lat_pre", prog_we, 0);
    idle(1);
    check("lat_rise", prog_we, 1);
    check("ack_pulse", in_ack, 0);
    send(22'h10, 16'h1212, 2'b01, 20, ok);
    check("pair_ack_b", ok, 1);
    wait_got("pair_count", 2, 40);
    check("pair_word0", got_q[0], {22'h10, 16'h3434, 2'b10});
    check("pair_word1", got_q[1], {22'h10, 16'h1212, 2'b01});
`endif

`ifdef JTFRAME_PROG_MERGE_EN
    // Address mismatch, then idle flush of the second byte
    got_q.delete();
    send(22'h10, 16'h5656, 2'b10, 20, ok);
    check("mis_ack_a", ok, 1);
    send(22'h11, 16'h7878, 2'b10, 20, ok);
    check("mis_ack_b", ok, 1);
    wait_got("mis_first", 1, 10);
    check("mis_word0", got_q[0], {22'h10, 16'h5656, 2'b10});
    cyc = 0;
    while (cyc < 40 && got_q.size() < 2) begin
      @(negedge clk);
      cyc++;
    end
    check("mis_flush_lo", (cyc >= 16), 1);
    check("mis_flush_hi", (cyc <= 22), 1);
    check("mis_word1", got_q.size() > 1 ? got_q[1] : 40'h0, {22'h11, 16'h7878, 2'b10});
`endif

    // Backpressure: SDRAM never acks, count accepted words
    got_q.delete();
    ack_en = 1'b0;
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      send(22'h20 + 22'(i), 16'hA000 + 16'(i), 2'b00, 20, ok);
      if (!ok) break;
      accepted++;
    end
    check("bp_accepted", accepted, DEPTH + 1);
    idle(50);
    check("bp_no_write", got_q.size(), 0);
    check("bp_we_held", prog_we, 1);
    ack_en = 1'b1;
    wait_got("bp_count", DEPTH + 1, 100);
    for (int i = 0; i < DEPTH + 1 && i < got_q.size(); i++)
      check($sformatf("bp_word%0d", i), got_q[i], {22'h20 + 22'(i), 16'hA000 + 16'(i), 2'b00});

    // End of download with an odd byte count
    got_q.delete();
    exp_w.delete();
    for (int k = 0; k < 7; k++) begin
      b = 8'h50 + 8'(k);
      send(22'h40 + 22'(k / 2), {b, b}, (k % 2 == 0) ? 2'b10 : 2'b01, 20, ok);
      check($sformatf("eod_ack%0d", k), ok, 1);
`ifndef JTFRAME_PROG_MERGE_EN
      exp_w.push_back({22'h40 + 22'(k / 2), b, b, (k % 2 == 0) ? 2'b10 : 2'b01});
`endif
    end
`ifdef JTFRAME_PROG_MERGE_EN
    exp_w.push_back({22'h40, 16'h5150, 2'b00});
    exp_w.push_back({22'h41, 16'h5352, 2'b00});
    exp_w.push_back({22'h42, 16'h5554, 2'b00});
    exp_w.push_back({22'h43, 16'h5656, 2'b10});
`endif
    downloading = 1'b0;
    check("eod_not_done", done, 0);
    for (int i = 0; i < 80 && !done; i++) @(negedge clk);
    check("eod_done", done, 1);
    check("eod_count", got_q.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_q.size(); i++)
      check($sformatf("eod_word%0d", i), got_q[i], exp_w[i]);

    // Reset while a write is pending with three more queued
    got_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(22'h60 + 22'(i), 16'hC000 + 16'(i), 2'b00, 20, ok);
      check($sformatf("rb_ack%0d", i), ok, 1);
    end
    idle(1);
    check("rb_we_before", prog_we, 1);
    rst_n = 1'b0;
    #1;
    check("rb_we_async", prog_we, 0);
    check("rb_mask_async", prog_mask, 2'b11);
    check("rb_done_async", done, 1);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    idle(20);
    check("rb_no_write", got_q.size(), 0);
    check("rb_we_after", prog_we, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
